// File: rtl/snn_pkg.sv
// Shared sizing and state encoding for the SNN layer sequencer.
package snn_pkg;

    localparam int N_IN  = 784;
    localparam int N_HID = 32;
    localparam int N_OUT = 10;

    localparam int AW_IN = $clog2(N_IN);
    localparam int AW_HW = $clog2(N_IN * N_HID);
    localparam int AW_HU = $clog2(N_HID);
    localparam int AW_OW = $clog2(N_HID * N_OUT);
    localparam int AW_OU = $clog2(N_OUT);
    localparam int NW    = (AW_HU > AW_OU) ? AW_HU : AW_OU;

    typedef enum logic [3:0] {
        IDLE,
        HID_MAC,
        HID_DRAIN,
        HID_WR,
        OUT_MAC,
        OUT_DRAIN,
        OUT_WR,
        ARG,
        DONE
    } seq_state_t;

endpackage

// File: rtl/snn_argmax.sv
// Running argmax over the output-unit scores; ties keep the earlier index.
module snn_argmax
    import snn_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             valid,
    input  logic [7:0]       value,
    input  logic [AW_OU-1:0] idx,
    output logic [AW_OU-1:0] best_idx
);

    logic [7:0]       r_best_val;
    logic [AW_OU-1:0] r_best_idx;
    logic             w_take;

    assign w_take = valid && (value > r_best_val);
    // Forward the in-flight compare so the final score lands in the same cycle.
    assign best_idx = w_take ? idx : r_best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_val <= '0;
            r_best_idx <= '0;
        end else if (clr) begin
            r_best_val <= '0;
            r_best_idx <= '0;
        end else if (w_take) begin
            r_best_val <= value;
            r_best_idx <= idx;
        end
    end

endmodule

// File: rtl/snn_seq.sv
// Layer sequencer: drives addresses, MAC control and RAM strobes for both
// layers, then scans the output-unit RAM and reports the classified digit.
module snn_seq
    import snn_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       q_output_unit,
    output logic             busy,
    output logic             done,
    output logic [3:0]       digit,
    output logic             layer_sel,
    output logic             mac_en,
    output logic             mac_clr,
    output logic [AW_IN-1:0] addr_input_unit,
    output logic [AW_HW-1:0] addr_hidden_weight,
    output logic [AW_HU-1:0] addr_hidden_unit,
    output logic [AW_OW-1:0] addr_output_weight,
    output logic [AW_OU-1:0] addr_output_unit,
    output logic             we_hidden,
    output logic             we_output
);

    localparam logic [AW_IN-1:0] LAST_IN = AW_IN'(N_IN - 1);
    localparam logic [AW_HU-1:0] LAST_HU = AW_HU'(N_HID - 1);
    localparam logic [AW_OU-1:0] LAST_OU = AW_OU'(N_OUT - 1);
    localparam logic [NW-1:0]    LAST_HN = NW'(N_HID - 1);
    localparam logic [NW-1:0]    LAST_ON = NW'(N_OUT - 1);

    seq_state_t       r_state;
    logic [NW-1:0]    r_neuron;
    logic             r_drain;
    logic             r_issue;
    logic             r_busy;
    logic             r_done;
    logic [3:0]       r_digit;
    logic             r_layer_sel;
    logic             r_mac_en;
    logic             r_mac_clr;
    logic [AW_IN-1:0] r_addr_in;
    logic [AW_HW-1:0] r_addr_hw;
    logic [AW_HU-1:0] r_addr_hu;
    logic [AW_OW-1:0] r_addr_ow;
    logic [AW_OU-1:0] r_addr_ou;
    logic             r_we_hidden;
    logic             r_we_output;
    logic             r_arg_vld;
    logic [AW_OU-1:0] r_arg_idx;
    logic [AW_OU-1:0] w_best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_neuron    <= '0;
            r_drain     <= 1'b0;
            r_issue     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_digit     <= '0;
            r_layer_sel <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_addr_in   <= '0;
            r_addr_hw   <= '0;
            r_addr_hu   <= '0;
            r_addr_ow   <= '0;
            r_addr_ou   <= '0;
            r_we_hidden <= 1'b0;
            r_we_output <= 1'b0;
        end else begin
            r_we_hidden <= 1'b0;
            r_we_output <= 1'b0;
            r_done      <= 1'b0;
            r_mac_clr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_neuron  <= '0;
                    r_addr_in <= '0;
                    r_addr_hw <= '0;
                    r_addr_hu <= '0;
                    r_addr_ow <= '0;
                    r_addr_ou <= '0;
                    if (start) begin
                        r_state <= HID_MAC;
                        r_busy  <= 1'b1;
                    end else begin
                        r_mac_clr <= 1'b1;
                    end
                end
                HID_MAC: begin
                    if (r_addr_in == LAST_IN) begin
                        r_state <= HID_DRAIN;
                    end else begin
                        r_addr_in <= r_addr_in + 1'b1;
                        r_addr_hw <= r_addr_hw + 1'b1;
                    end
                end
                // Cycle 1: last product accumulates; cycle 2: LUT read in flight.
                HID_DRAIN: begin
                    r_drain <= ~r_drain;
                    if (r_drain) begin
                        r_state     <= HID_WR;
                        r_we_hidden <= 1'b1;
                        r_mac_clr   <= 1'b1;
                        r_addr_hu   <= AW_HU'(r_neuron);
                        r_addr_in   <= '0;
                    end
                end
                HID_WR: begin
                    if (r_neuron == LAST_HN) begin
                        r_state     <= OUT_MAC;
                        r_layer_sel <= 1'b1;
                        r_neuron    <= '0;
                        r_addr_hw   <= '0;
                        r_addr_hu   <= '0;
                    end else begin
                        r_state   <= HID_MAC;
                        r_neuron  <= r_neuron + 1'b1;
                        r_addr_hw <= r_addr_hw + 1'b1;
                    end
                end
                OUT_MAC: begin
                    if (r_addr_hu == LAST_HU) begin
                        r_state <= OUT_DRAIN;
                    end else begin
                        r_addr_hu <= r_addr_hu + 1'b1;
                        r_addr_ow <= r_addr_ow + 1'b1;
                    end
                end
                OUT_DRAIN: begin
                    r_drain <= ~r_drain;
                    if (r_drain) begin
                        r_state     <= OUT_WR;
                        r_we_output <= 1'b1;
                        r_mac_clr   <= 1'b1;
                        r_addr_ou   <= AW_OU'(r_neuron);
                        r_addr_hu   <= '0;
                    end
                end
                OUT_WR: begin
                    if (r_neuron == LAST_ON) begin
                        r_state     <= ARG;
                        r_layer_sel <= 1'b0;
                        r_neuron    <= '0;
                        r_addr_ow   <= '0;
                        r_addr_hu   <= '0;
                        r_addr_ou   <= '0;
                        r_issue     <= 1'b1;
                    end else begin
                        r_state   <= OUT_MAC;
                        r_neuron  <= r_neuron + 1'b1;
                        r_addr_ow <= r_addr_ow + 1'b1;
                    end
                end
                // N_OUT issue cycles, then one trailing cycle for the last compare.
                ARG: begin
                    if (r_issue) begin
                        if (r_addr_ou == LAST_OU) r_issue <= 1'b0;
                        else                      r_addr_ou <= r_addr_ou + 1'b1;
                    end else begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_digit   <= 4'(w_best_idx);
                        r_addr_ou <= '0;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_mac_clr <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Data for an address issued in a MAC state is valid one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mac_en  <= 1'b0;
            r_arg_vld <= 1'b0;
            r_arg_idx <= '0;
        end else begin
            r_mac_en  <= (r_state == HID_MAC) || (r_state == OUT_MAC);
            r_arg_vld <= (r_state == ARG) && r_issue;
            r_arg_idx <= r_addr_ou;
        end
    end

    snn_argmax u_argmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (r_state != ARG),
        .valid    (r_arg_vld),
        .value    (q_output_unit),
        .idx      (r_arg_idx),
        .best_idx (w_best_idx)
    );

    assign busy               = r_busy;
    assign done               = r_done;
    assign digit              = r_digit;
    assign layer_sel          = r_layer_sel;
    assign mac_en             = r_mac_en;
    assign mac_clr            = r_mac_clr;
    assign addr_input_unit    = r_addr_in;
    assign addr_hidden_weight = r_addr_hw;
    assign addr_hidden_unit   = r_addr_hu;
    assign addr_output_weight = r_addr_ow;
    assign addr_output_unit   = r_addr_ou;
    assign we_hidden          = r_we_hidden;
    assign we_output          = r_we_output;

endmodule

// File: tb/tb_snn_seq.sv
// Bench for snn_seq: full inference runs against a sequence-level reference.
module tb_snn_seq;
    import snn_pkg::*;

    localparam int EXP_DONE = N_HID*(N_IN+3) + N_OUT*(N_HID+3) + N_OUT + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  q_output_unit = '0;
    logic        busy, done, layer_sel, mac_en, mac_clr, we_hidden, we_output;
    logic [3:0]  digit;
    logic [9:0]  addr_input_unit;
    logic [14:0] addr_hidden_weight;
    logic [4:0]  addr_hidden_unit;
    logic [8:0]  addr_output_weight;
    logic [3:0]  addr_output_unit;
    logic [53:0] outs;

    int errors = 0;
    int checks = 0;
    logic [7:0] ram [0:15];

    snn_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q_output_unit(q_output_unit),
        .busy(busy), .done(done), .digit(digit), .layer_sel(layer_sel),
        .mac_en(mac_en), .mac_clr(mac_clr), .addr_input_unit(addr_input_unit),
        .addr_hidden_weight(addr_hidden_weight), .addr_hidden_unit(addr_hidden_unit),
        .addr_output_weight(addr_output_weight), .addr_output_unit(addr_output_unit),
        .we_hidden(we_hidden), .we_output(we_output)
    );

    always #5 clk = ~clk;
    always @(posedge clk) q_output_unit <= ram[addr_output_unit];

    assign outs = {busy, done, digit, layer_sel, mac_en, mac_clr, addr_input_unit,
                   addr_hidden_weight, addr_hidden_unit, addr_output_weight,
                   addr_output_unit, we_hidden, we_output};

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mac_clr !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            {addr_input_unit, addr_hidden_weight, addr_hidden_unit,
             addr_output_weight, addr_output_unit} !== '0) begin
            errors++; $display("FAIL idle_state: mac_clr=%b busy=%b outs=%h want mac_clr=1 busy=0 addrs=0",
                               mac_clr, busy, outs);
        end
    endtask

    // One full inference; expectations come from the layer/issue rules and
    // a plain first-maximum search over the RAM image.
    task automatic test_run(input string name, input bit pulse_mid, input bit hold_start);
        int exp_digit, best, done_at, n_done, run_len, hid_iss, out_iss, bad_iss;
        int overlap, busy_bad, nwh, nwo, bad_we, last_ow, last_wh, hw784, bad_runs;
        int sp1, sp2, busy_c1, busy_a, busy_b, idle_ok, got_digit, end_digit;
        int runs[$];
        logic p_layer;
        logic [14:0] p_hw; logic [9:0] p_in; logic [8:0] p_ow; logic [4:0] p_hu;
        best = -1; exp_digit = 0;
        for (int i = 0; i < N_OUT; i++)
            if (int'(ram[i]) > best) begin best = int'(ram[i]); exp_digit = i; end
        done_at = -1; n_done = 0; run_len = 0; hid_iss = 0; out_iss = 0; bad_iss = 0;
        overlap = 0; busy_bad = 0; nwh = 0; nwo = 0; bad_we = 0; last_ow = -1;
        last_wh = -1; hw784 = -1; bad_runs = 0; busy_c1 = 0; busy_a = 1; busy_b = 0;
        idle_ok = 0; got_digit = -1; end_digit = -1;
        p_layer = 1'b0; p_hw = '0; p_in = '0; p_ow = '0; p_hu = '0;
        sp1 = $urandom_range(N_IN*N_HID - 10, 10);
        sp2 = $urandom_range(N_HID*(N_IN+3) + N_OUT*(N_HID+3) - 5, N_HID*(N_IN+3) + 5);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= EXP_DONE + 2; c++) begin
            if (c > 1) @(negedge clk);
            if (mac_en === 1'b1) begin
                run_len++;
                if (!p_layer) begin
                    if (int'(p_hw) != hid_iss || int'(p_in) != hid_iss % N_IN) bad_iss++;
                    if (hid_iss == N_IN) hw784 = int'(p_hw);
                    hid_iss++;
                end else begin
                    if (int'(p_ow) != out_iss || int'(p_hu) != out_iss % N_HID) bad_iss++;
                    last_ow = int'(p_ow);
                    out_iss++;
                end
            end else if (run_len > 0) begin
                runs.push_back(run_len); run_len = 0;
            end
            if (mac_en === 1'b1 && (we_hidden || we_output || mac_clr)) overlap++;
            if (we_hidden === 1'b1) begin
                if (int'(addr_hidden_unit) != nwh) bad_we++;
                last_wh = int'(addr_hidden_unit); nwh++;
            end
            if (we_output === 1'b1) begin
                if (int'(addr_output_unit) != nwo) bad_we++;
                nwo++;
            end
            if (c == 1) busy_c1 = int'(busy);
            if (c <= EXP_DONE && busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) begin done_at = c; got_digit = int'(digit); end
            end
            if (c == EXP_DONE + 1) begin
                busy_a = int'(busy);
                idle_ok = (mac_clr === 1'b1 && {addr_input_unit, addr_hidden_weight,
                           addr_hidden_unit, addr_output_weight, addr_output_unit} === '0);
            end
            if (c == EXP_DONE + 2) begin busy_b = int'(busy); end_digit = int'(digit); end
            start = (pulse_mid && (c == sp1 || c == sp2)) || (hold_start && c >= EXP_DONE - 1);
            p_layer = layer_sel; p_hw = addr_hidden_weight; p_in = addr_input_unit;
            p_ow = addr_output_weight; p_hu = addr_hidden_unit;
        end
        start = 1'b0;
        if (run_len > 0) runs.push_back(run_len);
        for (int r = 0; r < runs.size(); r++)
            if (runs[r] != ((r < N_HID) ? N_IN : N_HID)) bad_runs++;

        checks++; if (busy_c1 != 1) begin errors++; $display("FAIL %s busy_rise: got %0d want 1", name, busy_c1); end
        checks++; if (done_at != EXP_DONE) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_at, EXP_DONE); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", name, n_done); end
        checks++; if (got_digit != exp_digit) begin errors++; $display("FAIL %s digit: got %0d want %0d", name, got_digit, exp_digit); end
        checks++; if (end_digit != exp_digit) begin errors++; $display("FAIL %s digit_hold: got %0d want %0d", name, end_digit, exp_digit); end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL %s busy_drop: got %0d low cycles want 0", name, busy_bad); end
        checks++; if (busy_a != 0) begin errors++; $display("FAIL %s busy_fall: got %0d want 0", name, busy_a); end
        checks++; if (idle_ok != 1) begin errors++; $display("FAIL %s idle_after_done: got %0d want 1", name, idle_ok); end
        checks++; if (busy_b != int'(hold_start)) begin errors++; $display("FAIL %s restart: got %0d want %0d", name, busy_b, hold_start); end
        checks++; if (hid_iss != N_IN*N_HID || out_iss != N_HID*N_OUT) begin errors++; $display("FAIL %s issue_count: got %0d/%0d want %0d/%0d", name, hid_iss, out_iss, N_IN*N_HID, N_HID*N_OUT); end
        checks++; if (bad_iss != 0) begin errors++; $display("FAIL %s issue_addr: got %0d bad want 0", name, bad_iss); end
        checks++; if (hw784 != N_IN) begin errors++; $display("FAIL %s neuron1_base: got %0d want %0d", name, hw784, N_IN); end
        checks++; if (last_ow != N_HID*N_OUT - 1) begin errors++; $display("FAIL %s last_ow: got %0d want %0d", name, last_ow, N_HID*N_OUT - 1); end
        checks++; if (nwh != N_HID || nwo != N_OUT || bad_we != 0 || last_wh != N_HID - 1) begin errors++; $display("FAIL %s write_strobes: got %0d/%0d bad=%0d last=%0d want %0d/%0d bad=0 last=%0d", name, nwh, nwo, bad_we, last_wh, N_HID, N_OUT, N_HID - 1); end
        checks++; if (runs.size() != N_HID + N_OUT || bad_runs != 0) begin errors++; $display("FAIL %s mac_en_runs: got %0d runs bad=%0d want %0d bad=0", name, runs.size(), bad_runs, N_HID + N_OUT); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL %s mac_en_overlap: got %0d want 0", name, overlap); end
    endtask

    task automatic test_mid_reset;
        int was_busy;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (12000 - 1) @(negedge clk);
        was_busy = int'(busy);
        rst_n = 1'b0;
        #1;
        checks++;
        if (was_busy != 1 || outs !== '0) begin
            errors++; $display("FAIL mid_reset: busy_before=%0d outs=%h want 1 and 0", was_busy, outs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'd0;
        test_reset();

        ram[0] = 8'd10; ram[1] = 8'd20; ram[2] = 8'd250; ram[3] = 8'd30; ram[4] = 8'd250;
        test_run("tie_low", 1'b1, 1'b0);

        for (int i = 0; i < 9; i++) ram[i] = 8'($urandom_range(254, 0));
        ram[9] = 8'hFF;
        test_run("max_last", 1'b0, 1'b0);

        test_mid_reset();

        for (int i = 0; i < 16; i++) ram[i] = 8'd0;
        test_run("all_zero", 1'b0, 1'b1);

        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL final_reset: got %h want 0", outs); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
